mec_8255_bus_ctrl: RTL and testbench

//  Clocked bus master for the mec_8255 PPI. After reset it writes the 8255 mode word on its own.
//  It then turns single host requests (valid/ready) into timed Cs_n/A/Rd_n/Wr_n cycles.

---
 rtl/mec_8255_pkg.sv | 39 +++
 rtl/mec_8255_phase_timer.sv | 27 ++
 rtl/mec_8255_bus_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mec_8255_bus_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mec_8255_pkg.sv
// Shared types and constants for the mec_8255 bus controller: FSM states, 8255 port addresses,
// BSR control-word layout and the phase counter width.
package mec_8255_pkg;

  localparam int PHASE_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    K_INIT,
    K_HOST,
    K_BSR
  } kind_e;

  localparam logic [1:0] ADDR_PA   = 2'd0;
  localparam logic [1:0] ADDR_PB   = 2'd1;
  localparam logic [1:0] ADDR_PC   = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam int BSR_SET_POS = 0;
  localparam int BSR_BIT_LSB = 1;
  localparam int BSR_BIT_W   = 3;

  // Bit set/reset control word: D7=0 selects BSR mode, D3:D1 pick the PC bit, D0 is the value.
  function automatic logic [7:0] bsr_word(input logic [BSR_BIT_W-1:0] bit_sel, input logic set_val);
    logic [7:0] w;
    w = '0;
    w[BSR_SET_POS] = set_val;
    w[BSR_BIT_LSB +: BSR_BIT_W] = bit_sel;
    return w;
  endfunction

endpackage

// File: rtl/mec_8255_phase_timer.sv
// Loadable down-counter shared by the setup, strobe and hold phases.
// Load N-1 on phase entry; o_done is high during the last cycle of an N-cycle phase.
module mec_8255_phase_timer
  import mec_8255_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               i_load,
  input  logic [PHASE_W-1:0] i_val,
  output logic               o_done
);

  logic [PHASE_W-1:0] r_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/mec_8255_bus_ctrl.sv
// Sole 8255 bus master: writes CFG_WORD after reset, then runs setup/strobe/hold cycles per request.
// Response 1+SETUP+STROBE+HOLD edges after acceptance; MEC_8255_CTRL_BSR_EN adds a BSR request port.
module mec_8255_bus_ctrl
  import mec_8255_pkg::*;
#(
  parameter logic [7:0] CFG_WORD   = 8'h82,
  parameter int         SETUP_CYC  = 1,
  parameter int         STROBE_CYC = 2,
  parameter int         HOLD_CYC   = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       init_done,
  output logic       Cs_n,
  output logic       Rd_n,
  output logic       Wr_n,
  output logic [1:0] A,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in
`ifdef MEC_8255_CTRL_BSR_EN
  ,
  input  logic       bsr_valid,
  input  logic [2:0] bsr_bit,
  input  logic       bsr_set,
  output logic       bsr_ready,
  output logic       bsr_done
`endif
);

  localparam logic [PHASE_W-1:0] LD_SETUP  = PHASE_W'(SETUP_CYC - 1);
  localparam logic [PHASE_W-1:0] LD_STROBE = PHASE_W'(STROBE_CYC - 1);
  localparam logic [PHASE_W-1:0] LD_HOLD   = PHASE_W'(HOLD_CYC - 1);

  state_e             r_state;
  kind_e              r_kind;
  logic               r_wr;
  logic               w_done;
  logic               w_load;
  logic [PHASE_W-1:0] w_load_val;
  logic               w_illegal;

  assign req_ready = (r_state == S_IDLE) & init_done;
  assign w_illegal = ~req_wr & (req_addr == ADDR_CTRL);
`ifdef MEC_8255_CTRL_BSR_EN
  assign bsr_ready = (r_state == S_IDLE) & init_done & ~req_valid;
`endif

  // IDLE keeps the timer primed so SETUP starts with its count already loaded.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = LD_SETUP;
    case (r_state)
      S_IDLE:   w_load = 1'b1;
      S_SETUP:  begin w_load = w_done; w_load_val = LD_STROBE; end
      S_STROBE: begin w_load = w_done; w_load_val = LD_HOLD;   end
      default:  w_load = 1'b0;
    endcase
  end

  mec_8255_phase_timer u_timer (
    .Clk    (Clk),
    .Reset  (Reset),
    .i_load (w_load),
    .i_val  (w_load_val),
    .o_done (w_done)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_kind    <= K_INIT;
      r_wr      <= 1'b0;
      init_done <= 1'b0;
      Cs_n      <= 1'b1;
      Rd_n      <= 1'b1;
      Wr_n      <= 1'b1;
      A         <= '0;
      d_out     <= '0;
      d_oe      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef MEC_8255_CTRL_BSR_EN
      bsr_done  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!init_done) begin
            r_state <= S_SETUP;
            r_kind  <= K_INIT;
            r_wr    <= 1'b1;
            Cs_n    <= 1'b0;
            A       <= ADDR_CTRL;
            d_out   <= CFG_WORD;
            d_oe    <= 1'b1;
          end else if (req_valid) begin
            r_kind <= K_HOST;
            // The control register cannot be read back: answer with an error, no bus cycle.
            if (w_illegal) begin
              r_state   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              r_state <= S_SETUP;
              r_wr    <= req_wr;
              Cs_n    <= 1'b0;
              A       <= req_addr;
              d_out   <= req_wdata;
              d_oe    <= req_wr;
            end
          end
`ifdef MEC_8255_CTRL_BSR_EN
          else if (bsr_valid) begin
            r_state <= S_SETUP;
            r_kind  <= K_BSR;
            r_wr    <= 1'b1;
            Cs_n    <= 1'b0;
            A       <= ADDR_CTRL;
            d_out   <= bsr_word(bsr_bit, bsr_set);
            d_oe    <= 1'b1;
          end
`endif
        end
        S_SETUP: begin
          if (w_done) begin
            r_state <= S_STROBE;
            Wr_n    <= ~r_wr;
            Rd_n    <= r_wr;
          end
        end
        S_STROBE: begin
          if (w_done) begin
            r_state <= S_HOLD;
            Wr_n    <= 1'b1;
            Rd_n    <= 1'b1;
            if (!r_wr) rsp_rdata <= d_in;
          end
        end
        S_HOLD: begin
          if (w_done) begin
            Cs_n <= 1'b1;
            d_oe <= 1'b0;
            if (r_kind == K_INIT) begin
              r_state   <= S_IDLE;
              init_done <= 1'b1;
            end else begin
              r_state   <= S_RESP;
`ifdef MEC_8255_CTRL_BSR_EN
              rsp_valid <= (r_kind == K_HOST);
              bsr_done  <= (r_kind == K_BSR);
`else
              rsp_valid <= 1'b1;
`endif
            end
          end
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
`ifdef MEC_8255_CTRL_BSR_EN
          bsr_done  <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mec_8255_bus_ctrl.sv
// Bench for mec_8255_bus_ctrl: directed scenarios with literal expectations plus a random
// phase, all checked every cycle against a transaction-offset model of the 8255 bus timing.
module tb_mec_8255_bus_ctrl;
  import mec_8255_pkg::*;

  localparam int S = 1, ST = 2, H = 1, T = S + ST + H;
  localparam logic [7:0] CFG = 8'h82;

  logic       Clk = 1'b0, Reset = 1'b1;
  logic       req_valid = 1'b0, req_wr = 1'b0;
  logic [1:0] req_addr = '0;
  logic [7:0] req_wdata = '0, d_in = '0;
  logic       req_ready, rsp_valid, rsp_err, init_done, Cs_n, Rd_n, Wr_n, d_oe;
  logic [7:0] rsp_rdata, d_out;
  logic [1:0] A;

  mec_8255_bus_ctrl #(.CFG_WORD(CFG), .SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .init_done(init_done), .Cs_n(Cs_n), .Rd_n(Rd_n), .Wr_n(Wr_n), .A(A),
    .d_out(d_out), .d_oe(d_oe), .d_in(d_in)
  );

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Model: one outstanding transaction described by its first cycle, kind and fields.
  // kind 0 = init write, 1 = host bus cycle, 2 = illegal control read.
  bit         m_act = 0, m_init = 0;
  int         m_start = 0, m_end = 0, m_kind = 0;
  bit         m_wr = 0;
  logic [1:0] m_addr = '0;
  logic [7:0] m_data = '0, m_rdata = '0;

  always @(negedge Clk) begin : cmp
    int k;
    logic e_cs, e_rd, e_wr, e_oe, e_rv, e_err, e_rdy;
    bit idle_now;
    if (Reset) begin
      m_act = 0; m_init = 0; m_rdata = '0;
      chk("rst_A", A, 0);
      chk("rst_d_out", d_out, 0);
    end
    e_cs = 1; e_rd = 1; e_wr = 1; e_oe = 0; e_rv = 0; e_err = 0;
    if (m_act) begin
      k = cyc - m_start;
      if (m_kind == 2) begin
        e_rv = 1; e_err = 1;
      end else if (k < T) begin
        e_cs = 0; e_oe = m_wr;
        if (k >= S && k < S + ST) begin
          if (m_wr) e_wr = 0; else e_rd = 0;
        end
      end else begin
        e_rv = 1;
      end
    end
    e_rdy = !m_act && m_init;
    chk("Cs_n", Cs_n, e_cs);
    chk("Rd_n", Rd_n, e_rd);
    chk("Wr_n", Wr_n, e_wr);
    chk("d_oe", d_oe, e_oe);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("rsp_err", rsp_err, e_err);
    chk("rsp_rdata", rsp_rdata, m_rdata);
    chk("init_done", init_done, m_init);
    chk("req_ready", req_ready, e_rdy);
    if (!e_cs) chk("A", A, m_addr);
    if (e_oe) chk("d_out", d_out, m_data);
    if (!Reset) begin
      idle_now = !m_act;
      if (m_act && m_kind != 2 && !m_wr && cyc == m_start + S + ST - 1) m_rdata = d_in;
      if (m_act && cyc == m_end) begin
        m_act = 0;
        if (m_kind == 0) m_init = 1;
      end
      if (idle_now) begin
        if (!m_init) begin
          m_act = 1; m_kind = 0; m_start = cyc + 1; m_end = cyc + T;
          m_wr = 1; m_addr = ADDR_CTRL; m_data = CFG;
        end else if (req_valid) begin
          m_act = 1; m_start = cyc + 1;
          if (!req_wr && req_addr == ADDR_CTRL) begin
            m_kind = 2; m_end = cyc + 1;
          end else begin
            m_kind = 1; m_end = cyc + 1 + T;
            m_wr = req_wr; m_addr = req_addr; m_data = req_wdata;
          end
        end
      end
    end
  end

  task automatic watch_init(output int wl, output int aok, output int rv, output int done);
    bit bad;
    bad = 0; wl = 0; rv = 0; done = 0;
    for (int i = 0; i < 20 && done == 0; i++) begin
      @(negedge Clk);
      if (!Wr_n) begin
        wl++;
        if (A !== ADDR_CTRL || d_out !== CFG || Cs_n !== 1'b0) bad = 1;
      end
      if (rsp_valid) rv = 1;
      if (init_done) done = 1;
    end
    aok = (!bad && wl > 0) ? 1 : 0;
    @(posedge Clk); #1;
  endtask

  task automatic do_req(input logic wr, input logic [1:0] ad, input logic [7:0] wd,
                        input logic [7:0] din, output int lat, output int rd_lo,
                        output int wr_lo, output int cs_lo, output int oe_hi, output int acc_c,
                        output int rsp_c, output logic [7:0] rd, output logic er);
    bit got;
    lat = 0; rd_lo = 0; wr_lo = 0; cs_lo = 0; oe_hi = 0; acc_c = -1; rsp_c = -1;
    rd = '0; er = 0; got = 0;
    req_wr = wr; req_addr = ad; req_wdata = wd; d_in = din; req_valid = 1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clk);
      if (req_ready) begin got = 1; acc_c = cyc; end
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      req_valid = 0;
      return;
    end
    @(posedge Clk); #1 req_valid = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clk);
      lat++;
      if (!Rd_n) rd_lo++;
      if (!Wr_n) wr_lo++;
      if (!Cs_n) cs_lo++;
      if (d_oe) oe_hi++;
      if (rsp_valid) begin got = 1; rsp_c = cyc; rd = rsp_rdata; er = rsp_err; end
    end
    if (!got) chk("rsp_timeout", 0, 1);
    @(posedge Clk); #1;
  endtask

  initial begin
    int wl, aok, rv, dn, lat, rdl, wrl, csl, oeh, acc1, rsp1, acc2, rsp2;
    logic [7:0] rd;
    logic er;
    bit got;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_Cs_n", Cs_n, 1);       chk("reset_Rd_n", Rd_n, 1);
    chk("reset_Wr_n", Wr_n, 1);       chk("reset_d_oe", d_oe, 0);
    chk("reset_req_ready", req_ready, 0); chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0); chk("reset_rsp_err", rsp_err, 0);
    chk("reset_init_done", init_done, 0);
    @(posedge Clk); #1 Reset = 0;

    watch_init(wl, aok, rv, dn);
    chk("init_wr_low_cycles", wl, 2);
    chk("init_addr_data", aok, 1);
    chk("init_no_rsp", rv, 0);
    chk("init_done_set", dn, 1);

    do_req(1'b0, ADDR_PB, 8'h00, 8'hA5, lat, rdl, wrl, csl, oeh, acc1, rsp1, rd, er);
    chk("rd_latency", lat, 5);   chk("rd_strobe_cycles", rdl, 2);
    chk("rd_no_wr", wrl, 0);     chk("rd_oe_low", oeh, 0);
    chk("rd_data", rd, 8'hA5);   chk("rd_err", er, 0);

    do_req(1'b1, ADDR_PA, 8'h3C, 8'h00, lat, rdl, wrl, csl, oeh, acc1, rsp1, rd, er);
    chk("wr_latency", lat, 5);   chk("wr_strobe_cycles", wrl, 2);
    chk("wr_rdata_held", rd, 8'hA5);
    do_req(1'b0, ADDR_PB, 8'h00, 8'h5A, lat, rdl, wrl, csl, oeh, acc2, rsp2, rd, er);
    chk("b2b_accept_gap", acc2 - rsp1, 1);
    chk("b2b_order", (rsp2 > rsp1) ? 1 : 0, 1);
    chk("b2b_rd_data", rd, 8'h5A);

    do_req(1'b0, ADDR_CTRL, 8'h00, 8'hEE, lat, rdl, wrl, csl, oeh, acc1, rsp1, rd, er);
    chk("illegal_latency", lat, 1);   chk("illegal_no_cs", csl, 0);
    chk("illegal_err", er, 1);        chk("illegal_rdata", rd, 8'h5A);

    do_req(1'b1, ADDR_CTRL, 8'h80, 8'h00, lat, rdl, wrl, csl, oeh, acc1, rsp1, rd, er);
    chk("ctrl_write_err", er, 0);
    @(negedge Clk);
    chk("ctrl_write_init_kept", init_done, 1);
    @(posedge Clk); #1;

    req_wr = 1; req_addr = ADDR_PC; req_wdata = 8'hF0; req_valid = 1; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clk);
      if (req_ready) got = 1;
    end
    @(posedge Clk); #1 req_valid = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clk);
      if (!Wr_n) got = 1;
    end
    chk("strobe_reached", got, 1);
    @(posedge Clk); #2 Reset = 1;
    #1;
    chk("async_rst_Wr_n", Wr_n, 1);  chk("async_rst_Cs_n", Cs_n, 1);
    chk("async_rst_d_oe", d_oe, 0);  chk("async_rst_init_done", init_done, 0);
    repeat (2) @(posedge Clk);
    #1 Reset = 0;
    watch_init(wl, aok, rv, dn);
    chk("reinit_wr_low_cycles", wl, 2);
    chk("reinit_addr_data", aok, 1);
    chk("reinit_done", dn, 1);

    for (int i = 0; i < 2000; i++) begin
      @(posedge Clk); #1;
      req_valid = 1'($urandom_range(0, 1));
      req_wr    = 1'($urandom_range(0, 1));
      req_addr  = 2'($urandom_range(0, 3));
      req_wdata = 8'($urandom);
      d_in      = 8'($urandom);
      if ($urandom_range(0, 299) == 0) Reset = 1;
      else if (Reset && $urandom_range(0, 1) == 1) Reset = 0;
    end
    @(posedge Clk); #1 Reset = 0; req_valid = 0;
    repeat (20) @(posedge Clk);
    @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
